// File: rtl/dma_engine_pkg.sv
// Shared definitions for the DMA engine: state encoding and bus geometry.
// Consumed by dma_line_packer and dma_engine.
package dma_engine_pkg;

    localparam int DMA_WORD_SIZE        = 16;
    localparam int DMA_WORDS_PER_LINE   = 4;
    localparam int DMA_MEMORY_BANDWIDTH = DMA_WORD_SIZE * DMA_WORDS_PER_LINE;

    typedef enum logic [2:0] {
        DMA_IDLE    = 3'd0,
        DMA_FILL    = 3'd1,
        DMA_WAIT_BG = 3'd2,
        DMA_WRITE   = 3'd3,
        DMA_DONE    = 3'd4
    } dma_state_t;

endpackage

// File: rtl/dma_engine_line_packer.sv
// Source-side word packer: valid/ready handshake, slot counter and line register.
// A clear empties the line so the next fill starts again at slot 0.
module dma_line_packer
    import dma_engine_pkg::*;
#(
    parameter int WORD_SIZE      = DMA_WORD_SIZE,
    parameter int WORDS_PER_LINE = DMA_WORDS_PER_LINE
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_clear,
    input  logic                                 i_enable,
    input  logic                                 i_src_valid,
    input  logic [WORD_SIZE-1:0]                 i_src_data,
    output logic                                 o_src_ready,
    output logic                                 o_line_full,
    output logic                                 o_last_take,
    output logic [WORD_SIZE*WORDS_PER_LINE-1:0]  o_line
);

    localparam int SLOT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORDS_PER_LINE - 1);

    logic [SLOT_W-1:0]                          r_slot;
    logic                                       r_full;
    logic [WORDS_PER_LINE-1:0][WORD_SIZE-1:0]   r_line;
    logic                                       w_take;

    assign o_src_ready = i_enable & ~r_full;
    assign w_take      = o_src_ready & i_src_valid;
    assign o_last_take = w_take & (r_slot == LAST_SLOT);
    assign o_line_full = r_full;
    assign o_line      = r_line;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_slot <= '0;
            r_full <= 1'b0;
            r_line <= '0;
        end else if (i_clear) begin
            r_slot <= '0;
            r_full <= 1'b0;
        end else if (w_take) begin
            r_line[r_slot] <= i_src_data;
            if (r_slot == LAST_SLOT) begin
                r_slot <= '0;
                r_full <= 1'b1;
            end else begin
                r_slot <= r_slot + SLOT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dma_engine.sv
// DMA engine top: command FSM, line address/length counters and shared-bus drivers.
// Optional DMA_ENGINE_STATS_EN adds saturating lines_written / bg_wait_cycles counters.
module dma_engine
    import dma_engine_pkg::*;
#(
    parameter int WORD_SIZE      = DMA_WORD_SIZE,
    parameter int WORDS_PER_LINE = DMA_WORDS_PER_LINE,
    parameter int MEM_LATENCY    = 4,
    parameter int LEN_BITS       = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 DMA_cmd,
    input  logic [WORD_SIZE-1:0]                 cmd_address,
    input  logic [LEN_BITS-1:0]                  cmd_length,
    input  logic                                 src_valid,
    input  logic [WORD_SIZE-1:0]                 src_data,
    output logic                                 src_ready,
    output logic                                 BR,
    input  logic                                 BG,
    output logic                                 mem_writeM,
    output logic [WORD_SIZE-1:0]                 mem_address,
    inout  wire  [WORD_SIZE*WORDS_PER_LINE-1:0]  mem_data,
    output logic                                 DMA_begin,
    output logic                                 DMA_end,
    output logic                                 busy
`ifdef DMA_ENGINE_STATS_EN
    ,
    output logic [15:0]                          lines_written,
    output logic [15:0]                          bg_wait_cycles
`endif
);

    localparam int LINE_W = WORD_SIZE * WORDS_PER_LINE;
    localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0]     LAT_RELOAD = LAT_W'(MEM_LATENCY - 1);
    localparam logic [LEN_BITS-1:0]  LEN_STEP   = LEN_BITS'(WORDS_PER_LINE);
    localparam logic [LEN_BITS-1:0]  LEN_MASK   = ~LEN_BITS'(WORDS_PER_LINE - 1);
    localparam logic [WORD_SIZE-1:0] ADDR_STEP  = WORD_SIZE'(WORDS_PER_LINE);
    localparam logic [WORD_SIZE-1:0] ADDR_MASK  = ~WORD_SIZE'(WORDS_PER_LINE - 1);

    dma_state_t             r_state;
    dma_state_t             w_next;
    logic [WORD_SIZE-1:0]   r_addr;
    logic [LEN_BITS-1:0]    r_remaining;
    logic [LAT_W-1:0]       r_lat;
    logic                   r_begin;

    logic                   w_fill_en;
    logic                   w_last_take;
    logic                   w_line_full;
    logic [LINE_W-1:0]      w_line;
    logic                   w_line_done;
    logic                   w_addr_oe;
    logic                   w_data_oe;
    logic [LEN_BITS-1:0]    w_cmd_len;

    assign w_cmd_len   = cmd_length & LEN_MASK;
    assign w_line_done = (r_state == DMA_WRITE) & BG & (r_lat == '0);

    dma_line_packer #(
        .WORD_SIZE      (WORD_SIZE),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_packer (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clear     (w_line_done),
        .i_enable    (w_fill_en),
        .i_src_valid (src_valid),
        .i_src_data  (src_data),
        .o_src_ready (src_ready),
        .o_line_full (w_line_full),
        .o_last_take (w_last_take),
        .o_line      (w_line)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= DMA_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DMA_IDLE:    if (DMA_cmd) w_next = (w_cmd_len == '0) ? DMA_DONE : DMA_FILL;
            DMA_FILL:    if (w_last_take) w_next = BG ? DMA_WRITE : DMA_WAIT_BG;
            DMA_WAIT_BG: if (BG && w_line_full) w_next = DMA_WRITE;
            DMA_WRITE: begin
                // Losing the grant abandons the current strobe; the line is rewritten in full later.
                if (!BG)             w_next = DMA_WAIT_BG;
                else if (r_lat == '0) w_next = (r_remaining == LEN_STEP) ? DMA_DONE : DMA_FILL;
            end
            DMA_DONE:    w_next = DMA_IDLE;
            default:     w_next = DMA_IDLE;
        endcase
    end

    always_comb begin
        BR         = 1'b0;
        busy       = 1'b0;
        mem_writeM = 1'b0;
        w_fill_en  = 1'b0;
        DMA_end    = 1'b0;
        case (r_state)
            DMA_FILL: begin
                BR        = 1'b1;
                busy      = 1'b1;
                w_fill_en = 1'b1;
            end
            DMA_WAIT_BG: begin
                BR   = 1'b1;
                busy = 1'b1;
            end
            DMA_WRITE: begin
                BR         = 1'b1;
                busy       = 1'b1;
                mem_writeM = BG;
            end
            DMA_DONE: DMA_end = 1'b1;
            default: ;
        endcase
    end

    assign DMA_begin   = r_begin;
    assign w_addr_oe   = BR & BG;
    assign w_data_oe   = mem_writeM;
    assign mem_address = w_addr_oe ? r_addr : {WORD_SIZE{1'bz}};
    assign mem_data    = w_data_oe ? w_line : {LINE_W{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_lat       <= LAT_RELOAD;
            r_begin     <= 1'b0;
        end else begin
            r_begin <= (r_state == DMA_IDLE) & DMA_cmd;
            if ((r_state == DMA_IDLE) && DMA_cmd) begin
                r_addr      <= cmd_address & ADDR_MASK;
                r_remaining <= w_cmd_len;
            end else if (w_line_done) begin
                r_addr      <= r_addr + ADDR_STEP;
                r_remaining <= r_remaining - LEN_STEP;
            end
            if ((r_state == DMA_WRITE) && BG && (r_lat != '0)) r_lat <= r_lat - LAT_W'(1);
            else                                               r_lat <= LAT_RELOAD;
        end
    end

`ifdef DMA_ENGINE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lines_written  <= '0;
            bg_wait_cycles <= '0;
        end else begin
            if (w_line_done && (lines_written != 16'hFFFF))
                lines_written <= lines_written + 16'd1;
            if (BR && !BG && (bg_wait_cycles != 16'hFFFF))
                bg_wait_cycles <= bg_wait_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine (default build, stats disabled).
module tb_dma_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        DMA_cmd;
    logic [15:0] cmd_address;
    logic [7:0]  cmd_length;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_ready;
    logic        BR;
    logic        BG;
    logic        mem_writeM;
    wire  [15:0] mem_address;
    wire  [63:0] mem_data;
    logic        DMA_begin;
    logic        DMA_end;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_end   = 0;

    dma_engine dut (
        .clk         (clk),
        .reset       (reset),
        .DMA_cmd     (DMA_cmd),
        .cmd_address (cmd_address),
        .cmd_length  (cmd_length),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .BR          (BR),
        .BG          (BG),
        .mem_writeM  (mem_writeM),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .DMA_begin   (DMA_begin),
        .DMA_end     (DMA_end),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (DMA_end === 1'b1) n_end++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic start(input logic [15:0] addr, input logic [7:0] len);
        DMA_cmd     = 1'b1;
        cmd_address = addr;
        cmd_length  = len;
        cyc();
        DMA_cmd     = 1'b0;
    endtask

    // Feeds WORDS_PER_LINE consecutive words first, first+1, ...; optionally raises BG on the 2nd.
    task automatic feed(input logic [15:0] first, input bit raise_bg);
        logic [15:0] w;
        for (int k = 0; k < 4; k++) begin
            w = first + 16'(k);
            if (raise_bg && k == 1) BG = 1'b1;
            src_valid = 1'b1;
            src_data  = w;
            #1 chk("fill_src_ready", {63'd0, src_ready}, 64'd1);
            cyc();
        end
        src_valid = 1'b0;
    endtask

    task automatic write_line(input logic [15:0] addr, input logic [15:0] first);
        logic [15:0] w0, w1, w2, w3;
        w0 = first;
        w1 = first + 16'd1;
        w2 = first + 16'd2;
        w3 = first + 16'd3;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("wr_mem_writeM", {63'd0, mem_writeM}, 64'd1);
            chk("wr_address", {48'd0, mem_address}, {48'd0, addr});
            chk("wr_data", mem_data, {w3, w2, w1, w0});
            chk("wr_src_ready", {63'd0, src_ready}, 64'd0);
            chk("wr_data_oe", {63'd0, dut.w_data_oe}, 64'd1);
            cyc();
        end
    endtask

    task automatic chk_done(input int end_before);
        #1;
        chk("done_end", {63'd0, DMA_end}, 64'd1);
        chk("done_br", {63'd0, BR}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd0);
        chk("done_writeM", {63'd0, mem_writeM}, 64'd0);
        cyc();
        chk("idle_end", {63'd0, DMA_end}, 64'd0);
        chk("idle_br", {63'd0, BR}, 64'd0);
        chk("end_pulse_count", 64'(n_end - end_before), 64'd1);
    endtask

    int e0;

    initial begin
        reset = 1'b1; DMA_cmd = 1'b0; cmd_address = '0; cmd_length = '0;
        src_valid = 1'b0; src_data = '0; BG = 1'b0;
        cyc(); cyc();
        chk("rst_br", {63'd0, BR}, 64'd0);
        chk("rst_writeM", {63'd0, mem_writeM}, 64'd0);
        chk("rst_src_ready", {63'd0, src_ready}, 64'd0);
        chk("rst_begin", {63'd0, DMA_begin}, 64'd0);
        chk("rst_end", {63'd0, DMA_end}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_addr_oe", {63'd0, dut.w_addr_oe}, 64'd0);
        chk("rst_data_oe", {63'd0, dut.w_data_oe}, 64'd0);
        reset = 1'b0;
        cyc();

        // Basic transfer: 12 words from 01F0, grant one cycle after BR.
        e0 = n_end;
        start(16'h01F0, 8'd12);
        #1;
        chk("t1_br", {63'd0, BR}, 64'd1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_begin", {63'd0, DMA_begin}, 64'd1);
        feed(16'd1, 1'b1);
        write_line(16'h01F0, 16'd1);
        feed(16'd5, 1'b0);
        write_line(16'h01F4, 16'd5);
        feed(16'd9, 1'b0);
        write_line(16'h01F8, 16'd9);
        chk_done(e0);
        BG = 1'b0;

        // Late grant: BG low for 10 cycles after the line fills.
        e0 = n_end;
        start(16'h0100, 8'd4);
        feed(16'h0A00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t2_wait_writeM", {63'd0, mem_writeM}, 64'd0);
            chk("t2_wait_src_ready", {63'd0, src_ready}, 64'd0);
            chk("t2_wait_br", {63'd0, BR}, 64'd1);
            cyc();
        end
        BG = 1'b1;
        #1 chk("t2_bg_rise_writeM", {63'd0, mem_writeM}, 64'd0);
        cyc();
        write_line(16'h0100, 16'h0A00);
        chk_done(e0);

        // Grant loss in write cycle 2 of line 1, then full rewrite on regrant.
        e0 = n_end;
        start(16'h0200, 8'd8);
        feed(16'h0011, 1'b0);
        #1 chk("t3_wr1", {63'd0, mem_writeM}, 64'd1);
        cyc();
        BG = 1'b0;
        #1;
        chk("t3_drop_writeM", {63'd0, mem_writeM}, 64'd0);
        chk("t3_drop_addr_oe", {63'd0, dut.w_addr_oe}, 64'd0);
        chk("t3_drop_data_oe", {63'd0, dut.w_data_oe}, 64'd0);
        cyc();
        chk("t3_wait_writeM", {63'd0, mem_writeM}, 64'd0);
        chk("t3_wait_src_ready", {63'd0, src_ready}, 64'd0);
        BG = 1'b1;
        cyc();
        write_line(16'h0200, 16'h0011);
        feed(16'h0015, 1'b0);
        write_line(16'h0204, 16'h0015);
        chk_done(e0);

        // Zero length: DONE straight away, BR never asserted.
        BG = 1'b0;
        e0 = n_end;
        start(16'h0300, 8'd0);
        #1;
        chk("t4_zero_begin", {63'd0, DMA_begin}, 64'd1);
        chk_done(e0);

        // Command during FILL is ignored.
        BG = 1'b1;
        e0 = n_end;
        start(16'h0400, 8'd4);
        src_valid = 1'b1; src_data = 16'h0041;
        cyc();
        src_data = 16'h0042;
        DMA_cmd = 1'b1; cmd_address = 16'h0500; cmd_length = 8'd40;
        cyc();
        DMA_cmd = 1'b0;
        #1;
        chk("t4_ign_begin", {63'd0, DMA_begin}, 64'd0);
        chk("t4_ign_br", {63'd0, BR}, 64'd1);
        src_data = 16'h0043;
        cyc();
        src_data = 16'h0044;
        cyc();
        src_valid = 1'b0;
        write_line(16'h0400, 16'h0041);
        chk_done(e0);

        // Source gaps and address wrap.
        e0 = n_end;
        start(16'hFFFC, 8'd8);
        for (int ln = 0; ln < 2; ln++) begin
            for (int k = 0; k < 4; k++) begin
                src_valid = 1'b1;
                src_data  = 16'h0B00 + 16'(ln * 4 + k);
                cyc();
                if (k < 3) begin
                    src_valid = 1'b0;
                    src_data  = 16'hDEAD;
                    #1 chk("t5_gap_src_ready", {63'd0, src_ready}, 64'd1);
                    cyc();
                end
            end
            src_valid = 1'b0;
            write_line((ln == 0) ? 16'hFFFC : 16'h0000, 16'h0B00 + 16'(ln * 4));
        end
        chk_done(e0);

        // Synchronous reset during WRITE.
        e0 = n_end;
        start(16'h0600, 8'd8);
        feed(16'h0061, 1'b0);
        #1 chk("t6_wr1", {63'd0, mem_writeM}, 64'd1);
        cyc();
        reset = 1'b1;
        cyc();
        chk("t6_rst_br", {63'd0, BR}, 64'd0);
        chk("t6_rst_writeM", {63'd0, mem_writeM}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_end", {63'd0, DMA_end}, 64'd0);
        chk("t6_rst_addr_oe", {63'd0, dut.w_addr_oe}, 64'd0);
        chk("t6_rst_data_oe", {63'd0, dut.w_data_oe}, 64'd0);
        reset = 1'b0;
        cyc();
        chk("t6_no_end", 64'(n_end - e0), 64'd0);
        start(16'h0700, 8'd4);
        feed(16'h0071, 1'b0);
        write_line(16'h0700, 16'h0071);
        chk_done(e0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dma_engine.md
Name: dma_engine

Overview:
External DMA device paired with the CPU's DMA controller.
- On a CPU DMA command it takes a word stream from a source port and packs it into memory-bandwidth lines.
- It requests the memory bus (BR), waits for the grant (BG), and writes the lines to data memory at consecutive line addresses.
- It signals completion with a one-cycle end pulse.
- It sits on the memory side of the data-path DMA controller and drives the shared data-memory bus while granted.

Parameters:
- WORD_SIZE, 16, data/address word width
- WORDS_PER_LINE, 4, words per memory line (memory bandwidth = WORD_SIZE*WORDS_PER_LINE = 64)
- MEM_LATENCY, 4, cycles mem_writeM is held per line write (≥1)
- LEN_BITS, 8, width of the length field, in words

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- DMA_cmd  input  1  one-cycle start command from CPU
- cmd_address  input  WORD_SIZE  destination word address, line-aligned (low 2 bits ignored/zero)
- cmd_length  input  LEN_BITS  transfer length in words, multiple of WORDS_PER_LINE
- src_valid  input  1  source word available
- src_data  input  WORD_SIZE  source word
- src_ready  output  1  engine accepts source word this cycle
- BR  output  1  bus request to CPU
- BG  input  1  bus grant from CPU
- mem_writeM  output  1  memory write strobe
- mem_address  output  WORD_SIZE  line address; high-Z when not granted
- mem_data  inout  WORD_SIZE*WORDS_PER_LINE  line data; driven only while mem_writeM=1, else high-Z
- DMA_begin  output  1  one-cycle pulse on command acceptance
- DMA_end  output  1  one-cycle pulse on completion
- busy  output  1  transfer in progress

Behaviour:
- Reset values: state IDLE, BR=0, mem_writeM=0, src_ready=0, DMA_begin=0, DMA_end=0, busy=0, mem_address/mem_data high-Z. Counters and line buffer are cleared.
- States: IDLE, FILL, WAIT_BG, WRITE, DONE.
- IDLE:
  - DMA_cmd=1 latches address and length and pulses DMA_begin next cycle.
  - cmd_length=0 goes to DONE; BR is never asserted.
  - Otherwise the engine goes to FILL and asserts busy and BR. BR stays high until the DONE cycle.
  - DMA_cmd outside IDLE is ignored; there is no queueing.
- FILL:
  - src_ready=1 while the line is not full. A word is taken when src_valid&src_ready.
  - Word k goes in line slot k (slot 0 = bits [15:0]).
  - After slot WORDS_PER_LINE-1 the engine goes to WRITE if BG=1, else WAIT_BG.
  - src_valid gaps simply stall FILL.
- WAIT_BG: hold until BG=1, then go to WRITE. Line-buffer contents are preserved.
- WRITE:
  - mem_writeM=1, with mem_address = current line address and mem_data = line buffer, stable for exactly MEM_LATENCY cycles.
  - Then: line address += WORDS_PER_LINE (mod 2^WORD_SIZE, wraps silently) and remaining -= WORDS_PER_LINE.
  - If remaining = 0, go to DONE; else go to FILL.
  - src_ready=0 throughout WRITE.
- BG drop in WRITE: deassert mem_writeM and float the bus the same cycle, then go to WAIT_BG. The latency counter restarts; the same line is rewritten in full on regrant.
- DONE: for one cycle, DMA_end=1, BR=0 and busy=0, then return to IDLE.
- Minimum latency per line: WORDS_PER_LINE fill cycles + MEM_LATENCY write cycles, plus 1 cycle per transition.
- Reset mid-operation: immediate return to reset values. No DMA_end is issued and partial data is discarded.

Optional Feature:
DMA_ENGINE_STATS_EN
- Defined: adds output ports lines_written (16b, increments on each completed line write) and bg_wait_cycles (16b, increments each cycle BR=1 and BG=0). Both saturate at 16'hFFFF and clear only on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include: the state encoding constants (DMA_IDLE, DMA_FILL, DMA_WAIT_BG, DMA_WRITE, DMA_DONE), and the WORD_SIZE and MEMORY_BANDWIDTH macros shared with the opcode/cache headers.
- One natural sub-module: dma_line_packer, which does source handshake, slot counter and the line register, and exposes line_full and a clear input.
- The top holds the FSM, address/length counters and bus drivers.

Test Plan:
- Basic transfer: DMA_cmd with address 16'h01F0, length 12; src_valid held high with words 1..12; BG=1 one cycle after BR. Expect:
  - three writes of MEM_LATENCY cycles each, at 01F0, 01F4, 01F8;
  - the first line has mem_data = {4,3,2,1};
  - one DMA_end pulse, then BR low.
- Late grant: BG held 0 for 10 cycles after the line is full. Expect WAIT_BG for 10 cycles, no mem_writeM, src_ready=0, and the write to start the cycle after BG rises.
- Grant loss mid-write: drop BG at write cycle 2 of line 1. Expect mem_writeM to fall the same cycle and the bus to float; on regrant, the full MEM_LATENCY write of the identical line and address.
- Zero length and ignored command: cmd_length=0 gives a DMA_end pulse 1 cycle later with BR never high. A DMA_cmd during FILL is ignored, and the address/length are unchanged.
- Source gaps and wrap: src_valid toggling 1/0 with address 16'hFFFC, length 8. Expect correct packing and a second line at 16'h0000.
- Reset in WRITE: assert reset. Expect BR, mem_writeM and busy at 0, the bus high-Z next cycle, and no DMA_end. A new command afterwards completes normally.
